// File: rtl/sd_spi_byte_master.sv
// ============================================================================
// Module   : sd_spi_byte_master
// Function : SPI mode-0 byte master for an SD card. It shifts one byte out on
//            MOSI (MSB first) and captures one byte from MISO. The SCK
//            half-period is CLK_DIV_P system clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_spi_byte_master #(
  parameter logic [7:0] CLK_DIV_P = 8'd4
) (
  input  logic       clk_p,
  input  logic       rst_n_p,
  input  logic [7:0] data_to_transfer_p,
  input  logic       init_transfer_p,
  input  logic       spi_miso_p,
  output logic       spi_sck_p,
  output logic       spi_mosi_p,
  output logic       transfer_done_p,
  output logic [7:0] spi_data_in_p,
  output logic       busy_p
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCK_LOW  = 2'd1,
    SCK_HIGH = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [7:0] div_cnt, div_cnt_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] tx_shift, tx_shift_next;
  logic       sck_next, mosi_next, done_next, busy_next;
  logic [7:0] data_in_next;
  logic       div_last;

  // The last cycle of an SCK half-period; the divider never exceeds CLK_DIV_P-1.
  assign div_last = (div_cnt == (CLK_DIV_P - 8'd1));

  // Next-state and next-output decode; every value defaults to a hold.
  always_comb begin
    state_next    = state;
    div_cnt_next  = div_cnt;
    bit_cnt_next  = bit_cnt;
    tx_shift_next = tx_shift;
    sck_next      = spi_sck_p;
    mosi_next     = spi_mosi_p;
    done_next     = transfer_done_p;
    busy_next     = busy_p;
    data_in_next  = spi_data_in_p;
    case (state)
      IDLE: begin
        if (init_transfer_p) begin
          // The byte is captured here, so later input changes cannot disturb it.
          tx_shift_next = data_to_transfer_p;
          mosi_next     = data_to_transfer_p[7];
          data_in_next  = 8'h00;
          bit_cnt_next  = 3'd0;
          div_cnt_next  = 8'd0;
          busy_next     = 1'b1;
          state_next    = SCK_LOW;
        end
      end
      SCK_LOW: begin
        if (div_last) begin
          // On the rising edge, sample MISO into the LSB.
          sck_next     = 1'b1;
          data_in_next = {spi_data_in_p[6:0], spi_miso_p};
          div_cnt_next = 8'd0;
          state_next   = SCK_HIGH;
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end
      SCK_HIGH: begin
        if (div_last) begin
          sck_next     = 1'b0;
          div_cnt_next = 8'd0;
          if (bit_cnt == 3'd7) begin
            done_next  = 1'b1;
            mosi_next  = 1'b1;
            state_next = DONE;
          end else begin
            // On the falling edge, present the next MOSI bit.
            tx_shift_next = {tx_shift[6:0], 1'b0};
            mosi_next     = tx_shift[6];
            bit_cnt_next  = bit_cnt + 3'd1;
            state_next    = SCK_LOW;
          end
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end
      DONE: begin
        // Hold the result until the requester drops its request level.
        if (!init_transfer_p) begin
          done_next  = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_p) begin
    if (!rst_n_p) begin
      state           <= IDLE;
      div_cnt         <= 8'd0;
      bit_cnt         <= 3'd0;
      tx_shift        <= 8'd0;
      spi_sck_p       <= 1'b0;
      spi_mosi_p      <= 1'b1;
      transfer_done_p <= 1'b0;
      busy_p          <= 1'b0;
      spi_data_in_p   <= 8'h00;
    end else begin
      state           <= state_next;
      div_cnt         <= div_cnt_next;
      bit_cnt         <= bit_cnt_next;
      tx_shift        <= tx_shift_next;
      spi_sck_p       <= sck_next;
      spi_mosi_p      <= mosi_next;
      transfer_done_p <= done_next;
      busy_p          <= busy_next;
      spi_data_in_p   <= data_in_next;
    end
  end

endmodule

`default_nettype wire

// File: doc/sd_spi_byte_master.md
SD_SPI_BYTE_MASTER -- requirements
Module: sd_spi_byte_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV_P, default 8'd4, meaning the SCK half-period in clk_p cycles; legal range 4..255.
REQ-002 The block SHALL have port clk_p, input, 1, the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n_p, input, 1, reset; synchronous and active-low.
REQ-004 The block SHALL have port data_to_transfer_p, input, 8, the byte to shift out on MOSI, MSB first.
REQ-005 The block SHALL have port init_transfer_p, input, 1, the transfer request level, held high until done is seen.
REQ-006 The block SHALL have port spi_miso_p, input, 1, serial data from the SD card.
REQ-007 The block SHALL have port spi_sck_p, output, 1, the SPI clock (mode 0, idle low).
REQ-008 The block SHALL have port spi_mosi_p, output, 1, serial data to the SD card, idle high.
REQ-009 The block SHALL have port transfer_done_p, output, 1, high while the completed byte is held.
REQ-010 The block SHALL have port spi_data_in_p, output, 8, the byte received on MISO, MSB first.
REQ-011 The block SHALL have port busy_p, output, 1, high from request acceptance until return to IDLE.

Function
REQ-012 The block SHALL implement states IDLE, SCK_LOW, SCK_HIGH and DONE, plus an 8-bit divider counter and a 3-bit bit counter.
REQ-013 IDLE, init_transfer_p=1 -> next edge (cycle 0): latch data, spi_mosi_p<=data[7], spi_data_in_p<=0, bit counter<=0, divider<=0, busy_p<=1, go to SCK_LOW.
REQ-014 SCK_LOW: spi_sck_p=0; after CLK_DIV_P cycles in the state -> spi_sck_p<=1, shift spi_miso_p into the LSB of spi_data_in_p (left shift) on the same edge, go to SCK_HIGH.
REQ-015 SCK_HIGH: after CLK_DIV_P cycles -> spi_sck_p<=0; if bit counter=7, go to DONE with transfer_done_p<=1 and spi_mosi_p<=1; else spi_mosi_p<=next data bit, bit counter +1, go to SCK_LOW.
REQ-016 Timing SHALL be exact: rising SCK edges at cycles (2k+1)*CLK_DIV_P and falling at (2k+2)*CLK_DIV_P, k=0..7; transfer_done_p rises at cycle 16*CLK_DIV_P.
REQ-017 spi_data_in_p SHALL be stable and valid whenever transfer_done_p=1.
REQ-018 DONE: hold transfer_done_p=1, spi_sck_p=0, spi_mosi_p=1 while init_transfer_p=1; when init_transfer_p=0 -> next edge transfer_done_p<=0, busy_p<=0, go to IDLE.
REQ-019 A new request SHALL be accepted only in IDLE; at least one IDLE cycle SHALL separate consecutive transfers.
REQ-020 Changes on data_to_transfer_p after cycle 0 SHALL NOT affect the byte in flight.
REQ-021 A deassertion of init_transfer_p mid-transfer SHALL be ignored; the byte completes and DONE exits immediately.
REQ-022 The divider SHALL reset to 0 on each SCK edge; no arithmetic wrap is permitted within the legal CLK_DIV_P range.

Reset
REQ-023 While rst_n_p=0 at a clock edge: state<=IDLE, spi_sck_p=0, spi_mosi_p=1, transfer_done_p=0, busy_p=0, spi_data_in_p=8'h00, all counters 0.
REQ-024 Reset mid-transfer SHALL abort immediately with no further SCK edges; the next request after release restarts from bit 7.

Verification
REQ-025 Drive 0xA5 with an SD slave model returning 0x3C, CLK_DIV_P=4 -> slave receives 0xA5; spi_data_in_p=0x3C; transfer_done_p rises at cycle 64; 8 SCK pulses each 4 high / 4 low.
REQ-026 Hold init_transfer_p high for 20 cycles after done -> done stays 1, no SCK activity; drop request -> done=0 and busy=0 one cycle later.
REQ-027 Assert reset at cycle 30 of a transfer -> next edge sck=0, mosi=1, busy=0; a new 0xFF transfer then completes normally with 0xFF sent.
REQ-028 Two back-to-back bytes 0x40, 0x95 with slave returning 0xFF,0x01 -> results 0xFF then 0x01; exactly 16 SCK rising edges total.
REQ-029 CLK_DIV_P=8, byte 0x00, MISO tied 1 -> done at cycle 128; spi_data_in_p=0xFF; MOSI low for the whole frame.
